serial_2of5_encoder: RTL and testbench

Upstream feeder for the serial 2-of-5 TOFED checker. Accepts decimal digits (BCD) over a valid/ready handshake, encodes each one to a 5-bit 2-of-5 codeword, and shifts the codeword out MSB-first, one bit per clock. Back-to-back digits produce a gapless stream, so the downstream checker's 5-bit framing never slips.

---
 rtl/serial_2of5_encoder_pkg.sv | 32 +++
 rtl/serial_2of5_encoder_encode.sv | 26 ++
 rtl/serial_2of5_encoder.sv | 141 ++++++++++++++
 tb/tb_serial_2of5_encoder.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/serial_2of5_encoder_pkg.sv
// ============================================================================
// Module   : SerialTOFEDDefs_2of5 (package)
// Purpose  : Shared 2-of-5 serial TOFED definitions: sizes, states, code table
// Revision : 1.0
// ============================================================================
`default_nettype none

package SerialTOFEDDefs_2of5;

  localparam int FBIBBLE_SIZE   = 5;
  localparam int ONESPERFBIBBLE = 2;

  typedef logic bool_t;

  typedef enum logic [0:0] {
    ENC_IDLE  = 1'b0,
    ENC_SHIFT = 1'b1
  } enc_state_t;

  // Weights 7-4-2-1-0, MSB first; zero uses the 7+4 pair.
  localparam logic [FBIBBLE_SIZE-1:0] TWOOF5_TABLE [10] = '{
    5'b11000, 5'b00011, 5'b00101, 5'b00110, 5'b01001,
    5'b01010, 5'b01100, 5'b10001, 5'b10010, 5'b10100
  };

  function automatic bool_t is_bcd(input logic [3:0] digit);
    return (digit <= 4'd9);
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_2of5_encoder_encode.sv
// ============================================================================
// Module   : twoof5_encode
// Purpose  : Combinational BCD digit to 2-of-5 codeword lookup with valid flag
// Revision : 1.0
// ============================================================================
`default_nettype none

module twoof5_encode
  import SerialTOFEDDefs_2of5::*;
(
  input  logic [3:0]              digit_i,
  output logic [FBIBBLE_SIZE-1:0] codeword_o,
  output logic                    valid_o
);

  logic [3:0] idx_w;

  always_comb begin
    valid_o    = is_bcd(digit_i);
    idx_w      = valid_o ? digit_i : 4'd0;
    codeword_o = valid_o ? TWOOF5_TABLE[idx_w] : '0;
  end

endmodule

`default_nettype wire

// File: rtl/serial_2of5_encoder.sv
// ============================================================================
// Module   : serial_2of5_encoder
// Purpose  : Accepts BCD digits over valid/ready and streams gapless 2-of-5
//            codewords MSB first. Optional macro TOFED_ERR_INJECT_EN adds the
//            inject_err port that flips the LSB of a loaded codeword.
// Revision : 1.0
// ============================================================================
`default_nettype none

module serial_2of5_encoder
  import SerialTOFEDDefs_2of5::*;
(
  input  logic       clk,
  input  logic       resetL,
  input  logic [3:0] digit_in,
  input  logic       digit_valid,
`ifdef TOFED_ERR_INJECT_EN
  input  logic       inject_err,
`endif
  output logic       digit_ready,
  output logic       serialOut,
  output logic       serialValid,
  output logic       frameStart,
  output logic       bcd_err
);

  localparam logic [2:0] LAST_BIT = 3'(FBIBBLE_SIZE - 1);

  enc_state_t              state_q, state_d;
  logic [2:0]              cnt_q, cnt_d;
  logic [FBIBBLE_SIZE-1:0] shreg_q, shreg_d;
  logic                    serial_out_q, serial_out_d;
  logic                    serial_valid_q, serial_valid_d;
  logic                    frame_start_q, frame_start_d;
  logic                    bcd_err_q, bcd_err_d;

  logic [FBIBBLE_SIZE-1:0] enc_code_w;
  logic                    enc_valid_w;
  logic [FBIBBLE_SIZE-1:0] load_word_w;
  logic                    inj_w;
  logic                    xfer_w;
  logic                    load_w;

  twoof5_encode u_encode (
    .digit_i    (digit_in),
    .codeword_o (enc_code_w),
    .valid_o    (enc_valid_w)
  );

`ifdef TOFED_ERR_INJECT_EN
  assign inj_w = inject_err;
`else
  assign inj_w = 1'b0;
`endif

  assign load_word_w = enc_code_w ^ {{(FBIBBLE_SIZE-1){1'b0}}, inj_w};

  // Ready in the last bit slot lets the next codeword follow with no gap.
  assign digit_ready = (state_q == ENC_IDLE) ||
                       ((state_q == ENC_SHIFT) && (cnt_q == LAST_BIT));
  assign xfer_w      = digit_valid && digit_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    bcd_err_d = 1'b0;
    load_w    = 1'b0;

    case (state_q)
      ENC_IDLE: begin
        if (xfer_w) begin
          if (enc_valid_w) load_w    = 1'b1;
          else             bcd_err_d = 1'b1;
        end
      end
      ENC_SHIFT: begin
        if (cnt_q != LAST_BIT) begin
          shreg_d = shreg_q << 1;
          cnt_d   = cnt_q + 3'd1;
        end else if (xfer_w && enc_valid_w) begin
          load_w = 1'b1;
        end else begin
          bcd_err_d = xfer_w;
          state_d   = ENC_IDLE;
          cnt_d     = 3'd0;
          shreg_d   = '0;
        end
      end
      default: begin
        state_d = ENC_IDLE;
        cnt_d   = 3'd0;
        shreg_d = '0;
      end
    endcase

    if (load_w) begin
      state_d = ENC_SHIFT;
      cnt_d   = 3'd0;
      shreg_d = load_word_w;
    end

    serial_valid_d = (state_d == ENC_SHIFT);
    serial_out_d   = serial_valid_d && shreg_d[FBIBBLE_SIZE-1];
    frame_start_d  = serial_valid_d && (cnt_d == 3'd0);
  end

  always_ff @(posedge clk or negedge resetL) begin
    if (!resetL) begin
      state_q        <= ENC_IDLE;
      cnt_q          <= 3'd0;
      shreg_q        <= '0;
      serial_out_q   <= 1'b0;
      serial_valid_q <= 1'b0;
      frame_start_q  <= 1'b0;
      bcd_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      shreg_q        <= shreg_d;
      serial_out_q   <= serial_out_d;
      serial_valid_q <= serial_valid_d;
      frame_start_q  <= frame_start_d;
      bcd_err_q      <= bcd_err_d;
    end
  end

  assign serialOut   = serial_out_q;
  assign serialValid = serial_valid_q;
  assign frameStart  = frame_start_q;
  assign bcd_err     = bcd_err_q;

  // Every codeword committed to the line is legal unless deliberately corrupted.
  a_ones_count : assert property (
    @(posedge clk) disable iff (!resetL)
      load_w |-> (inj_w || ($countones(load_word_w) == ONESPERFBIBBLE))
  );

endmodule

`default_nettype wire

// File: tb/tb_serial_2of5_encoder.sv
// ============================================================================
// Module   : tb_serial_2of5_encoder
// Purpose  : Randomized self-checking bench with a bit-stream reference model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_serial_2of5_encoder;

  logic       clk = 1'b0;
  logic       resetL = 1'b0;
  logic [3:0] digit_in = 4'd0;
  logic       digit_valid = 1'b0;
  logic       inj_drv = 1'b0;
  logic       digit_ready, serialOut, serialValid, frameStart, bcd_err;

  serial_2of5_encoder dut (
    .clk         (clk),
    .resetL      (resetL),
    .digit_in    (digit_in),
    .digit_valid (digit_valid),
`ifdef TOFED_ERR_INJECT_EN
    .inject_err  (inj_drv),
`endif
    .digit_ready (digit_ready),
    .serialOut   (serialOut),
    .serialValid (serialValid),
    .frameStart  (frameStart),
    .bcd_err     (bcd_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: bits of the current codeword still to be seen on the line.
  int         rem = 0;
  logic [4:0] cw  = 5'd0;
  logic       err_exp = 1'b0;
  logic       acc = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
  endtask

  // Derive the codeword from the 7-4-2-1-0 weight rule rather than a table.
  function automatic logic [4:0] ref_code(input int d);
    int w[5] = '{7, 4, 2, 1, 0};
    logic [4:0] r = 5'd0;
    bit found = 0;
    for (int i = 0; i < 5; i++)
      for (int j = i + 1; j < 5; j++)
        if (!found && ((w[i] + w[j] == d) || (d == 0 && w[i] + w[j] == 11))) begin
          r[4-i] = 1'b1;
          r[4-j] = 1'b1;
          found  = 1;
        end
    return r;
  endfunction

  task automatic check_outputs();
    logic sv_e, so_e;
    sv_e = (rem > 0);
    so_e = sv_e ? cw[rem-1] : 1'b0;
    check_eq("serialValid", 32'(serialValid), 32'(sv_e));
    check_eq("serialOut",   32'(serialOut),   32'(so_e));
    check_eq("frameStart",  32'(frameStart),  32'(rem == 5));
    check_eq("bcd_err",     32'(bcd_err),     32'(err_exp));
    check_eq("digit_ready", 32'(digit_ready), 32'(rem <= 1));
  endtask

  task automatic step(input logic v, input logic [3:0] d, input logic inj);
    logic rdy;
    digit_valid = v;
    digit_in    = d;
    inj_drv     = inj;
    rdy         = (rem <= 1);
    @(posedge clk);
    err_exp = 1'b0;
    acc     = v && rdy;
    if (acc) begin
      if (d <= 4'd9) begin
        cw  = ref_code(int'(d));
`ifdef TOFED_ERR_INJECT_EN
        cw[0] = cw[0] ^ inj;
`endif
        rem = 5;
      end else begin
        err_exp = 1'b1;
        rem     = 0;
      end
    end else if (rem > 0) begin
      rem--;
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic send(input logic [3:0] d, input logic inj);
    int guard = 0;
    do begin
      step(1'b1, d, inj);
      guard++;
    end while (!acc && guard < 10);
    if (!acc) check_eq("accept_timeout", 32'(guard), 32'(0));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_outputs();
    resetL = 1'b1;
    @(negedge clk);
    check_outputs();

    send(4'd7, 1'b0);
    idle(6);

    for (int d = 0; d < 10; d++) send(4'(d), 1'b0);
    idle(6);

    step(1'b1, 4'd12, 1'b0);
    idle(3);

    send(4'd3, 1'b0);
    send(4'd11, 1'b0);
    send(4'd5, 1'b0);
    idle(6);

    send(4'd9, 1'b0);
    idle(2);
    resetL = 1'b0;
    #1;
    rem = 0;
    err_exp = 1'b0;
    check_eq("rst_serialValid", 32'(serialValid), 32'(0));
    check_eq("rst_serialOut",   32'(serialOut),   32'(0));
    check_eq("rst_frameStart",  32'(frameStart),  32'(0));
    @(negedge clk);
    resetL = 1'b1;
    send(4'd1, 1'b0);
    idle(6);

`ifdef TOFED_ERR_INJECT_EN
    send(4'd4, 1'b1);
    idle(6);
`endif

    for (int n = 0; n < 3000; n++) begin
      logic       v, inj;
      logic [3:0] d;
      v   = ($urandom_range(0, 9) < 7);
      d   = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
`ifdef TOFED_ERR_INJECT_EN
      inj = ($urandom_range(0, 7) == 0);
`else
      inj = 1'b0;
`endif
      step(v, d, inj);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
